sdiv_seq: RTL

Sequential signed 32-bit divider; the inverse operation of the team's Baugh-Wooley multiplier datapath. Computes truncating quotient and remainder of two two's-complement operands with a radix-2 restoring algorithm, one quotient bit per clock. Sits beside the multiplier in the arithmetic unit behind a start/done handshake.

---
 rtl/sdiv_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdiv_seq.sv
// sdiv_seq: sequential signed divider, radix-2 restoring, one quotient bit per clock.
// Truncating quotient; a nonzero remainder takes the sign of the dividend.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_i    synchronous active-high reset; aborts any division in progress
//   start_i  request, sampled only while idle
//   a_i/b_i  dividend / divisor, two's complement, needed only at accept
//   busy_o   division in progress
//   done_o   one-cycle pulse; q_o, r_o, dbz_o valid and held until next completion
//   q_o/r_o  quotient / remainder
//   dbz_o    divide-by-zero flag for the result on q_o/r_o
// Optional feature: define SDIV_EARLY_OUT_EN to let b==0 and (min / -1)
// bypass the iteration loop (done two cycles after accept).
module sdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             dbz_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] qo_q, qo_d;
  logic [WIDTH-1:0] ro_q, ro_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;

  assign abs_a_c   = a_i[WIDTH-1] ? WIDTH'(-a_i) : a_i;
  assign abs_b_c   = b_i[WIDTH-1] ? WIDTH'(-b_i) : b_i;
  assign shifted_c = {rem_q, quo_q[WIDTH-1]};
  assign trial_c   = shifted_c - divisor_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef SDIV_EARLY_OUT_EN
          if ((b_i == '0) || ((a_i == MIN_VAL) && (b_i == '1))) state_d = S_FIX;
          else                                                  state_d = S_DIV;
`else
          state_d = S_DIV;
`endif
        end
      end
      S_DIV:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    qo_d      = qo_q;
    ro_d      = ro_q;
    dbz_d     = dbz_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d       = a_i;
          b_d       = b_i;
          sign_q_d  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          sign_r_d  = a_i[WIDTH-1];
          quo_d     = abs_a_c;
          divisor_d = {1'b0, abs_b_c};
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      S_DIV: begin
        // trial MSB set means the shifted remainder is below the divisor
        if (trial_c[WIDTH]) begin
          rem_d = shifted_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = trial_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        if (b_q == '0) begin
          quo_d = '1;
          rem_d = a_q;
          dz_d  = 1'b1;
        end else if ((a_q == MIN_VAL) && (b_q == '1)) begin
          quo_d = a_q;
          rem_d = '0;
          dz_d  = 1'b0;
        end else begin
          quo_d = sign_q_q ? WIDTH'(-quo_q) : quo_q;
          rem_d = sign_r_q ? WIDTH'(-rem_q) : rem_q;
          dz_d  = 1'b0;
        end
      end
      S_DONE: begin
        qo_d  = quo_q;
        ro_d  = rem_q;
        dbz_d = dz_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      qo_q      <= '0;
      ro_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      qo_q      <= qo_d;
      ro_q      <= ro_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o    = qo_q;
  assign r_o    = ro_q;
  assign dbz_o  = dbz_q;

endmodule
